// File: rtl/dma_word_access_buffer.sv
// -----------------------------------------------------------------------------
// dma_word_access_buffer
//
// Purpose:
//   Byte-serial access buffer between the 8-bit CPU data bus and the
//   per-channel address/count register words of a DMA controller.
//   - Writes: bytes are collected in a staging word through a byte pointer
//     shared by every register. The full word is committed in one step on the
//     final byte, so the base words never show a half-written value.
//   - Reads: the first byte of a word takes a snapshot of the live value. Later
//     bytes come from that snapshot, so a counting register cannot tear.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   data_bus          write byte from the CPU
//   reg_addr          register address: 2*ch = address, 2*ch+1 = count;
//                     CLR_FF_ADDR / MCLR_ADDR are write-only commands
//   wr_en, rd_en      one-byte write / read strobes (write wins if both)
//   cur_addr_flat     live current-address words, channel c at [c*WORD_W +: WORD_W]
//   cur_count_flat    live current-count words, same packing
//   rd_data, rd_valid read byte and its one-cycle valid pulse (latency 1)
//   base_addr_flat    committed address words
//   base_count_flat   committed count words
//   commit            one-cycle pulse after a word has been committed
//   commit_ch         channel of that commit
//   commit_is_count   1 = count register, 0 = address register
//   byte_ptr          current byte pointer (0 = least significant byte)
// -----------------------------------------------------------------------------
module dma_word_access_buffer #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WORD_BYTES  = 2,
  parameter logic [3:0]  CLR_FF_ADDR = 4'hC,
  parameter logic [3:0]  MCLR_ADDR   = 4'hD,
  localparam int unsigned WORD_W     = DATA_W * WORD_BYTES,
  localparam int unsigned PTR_W      = $clog2(WORD_BYTES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_bus,
  input  logic [3:0]               reg_addr,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [NUM_CH*WORD_W-1:0] cur_addr_flat,
  input  logic [NUM_CH*WORD_W-1:0] cur_count_flat,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [NUM_CH*WORD_W-1:0] base_addr_flat,
  output logic [NUM_CH*WORD_W-1:0] base_count_flat,
  output logic                     commit,
  output logic [1:0]               commit_ch,
  output logic                     commit_is_count,
  output logic [PTR_W-1:0]         byte_ptr
);

  typedef logic [WORD_BYTES-1:0][DATA_W-1:0] word_t;

  // State
  logic [PTR_W-1:0]  ptr_q,             ptr_d;
  word_t             staging_q,         staging_d;
  word_t             snap_q,            snap_d;
  logic [WORD_W-1:0] base_addr_q [NUM_CH];
  logic [WORD_W-1:0] base_addr_d [NUM_CH];
  logic [WORD_W-1:0] base_count_q[NUM_CH];
  logic [WORD_W-1:0] base_count_d[NUM_CH];
  logic [DATA_W-1:0] rd_data_q,         rd_data_d;
  logic              rd_valid_q,        rd_valid_d;
  logic              commit_q,          commit_d;
  logic [1:0]        commit_ch_q,       commit_ch_d;
  logic              commit_is_count_q, commit_is_count_d;

  // Address decode
  logic [2:0]       ch_idx;
  logic             is_count;
  logic             reg_hit;
  logic             last_byte;
  logic [PTR_W-1:0] ptr_next;
  word_t            cur_word;

  assign ch_idx    = reg_addr[3:1];
  assign is_count  = reg_addr[0];
  assign reg_hit   = reg_addr < 4'(2 * NUM_CH);
  assign last_byte = ptr_q == PTR_W'(WORD_BYTES - 1);
  assign ptr_next  = last_byte ? '0 : ptr_q + PTR_W'(1);

  // Live value of the addressed register, used as the read snapshot source.
  always_comb begin
    cur_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == 3'(c)) begin
        cur_word = is_count ? cur_count_flat[c*WORD_W +: WORD_W]
                            : cur_addr_flat[c*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
    ptr_d             = ptr_q;
    staging_d         = staging_q;
    snap_d            = snap_q;
    base_addr_d       = base_addr_q;
    base_count_d      = base_count_q;
    rd_data_d         = rd_data_q;
    rd_valid_d        = 1'b0;
    commit_d          = 1'b0;
    commit_ch_d       = commit_ch_q;
    commit_is_count_d = commit_is_count_q;

    if (wr_en) begin
      // A write always wins; a simultaneous read is dropped entirely.
      if (reg_hit) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (ptr_q == PTR_W'(b)) staging_d[b] = data_bus;
        end
        ptr_d = ptr_next;
        if (last_byte) begin
          // NOTE: staging_d is read back after the blocking update above, so the committed word already holds the final byte.
          commit_d          = 1'b1;
          commit_ch_d       = ch_idx[1:0];
          commit_is_count_d = is_count;
          for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 3'(c)) begin
              if (is_count) base_count_d[c] = staging_d;
              else          base_addr_d[c]  = staging_d;
            end
          end
        end
      end else if (reg_addr == CLR_FF_ADDR) begin
        ptr_d = '0;
      end else if (reg_addr == MCLR_ADDR) begin
        ptr_d     = '0;
        staging_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          base_addr_d[c]  = '0;
          base_count_d[c] = '0;
        end
      end
    end else if (rd_en && reg_hit) begin
      // The first byte freezes the whole word; later bytes replay the frozen copy.
      if (ptr_q == '0) begin
        snap_d    = cur_word;
        rd_data_d = cur_word[0];
      end else begin
        for (int b = 1; b < WORD_BYTES; b++) begin
          if (ptr_q == PTR_W'(b)) rd_data_d = snap_q[b];
        end
      end
      ptr_d      = ptr_next;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q             <= '0;
      staging_q         <= '0;
      snap_q            <= '0;
      rd_data_q         <= '0;
      rd_valid_q        <= 1'b0;
      commit_q          <= 1'b0;
      commit_ch_q       <= '0;
      commit_is_count_q <= 1'b0;
      // NOTE: the register words are cleared on reset because software expects zeros; a plain storage array would be left unreset.
      for (int c = 0; c < NUM_CH; c++) begin
        base_addr_q[c]  <= '0;
        base_count_q[c] <= '0;
      end
    end else begin
      ptr_q             <= ptr_d;
      staging_q         <= staging_d;
      snap_q            <= snap_d;
      rd_data_q         <= rd_data_d;
      rd_valid_q        <= rd_valid_d;
      commit_q          <= commit_d;
      commit_ch_q       <= commit_ch_d;
      commit_is_count_q <= commit_is_count_d;
      base_addr_q       <= base_addr_d;
      base_count_q      <= base_count_d;
    end
  end

  // Outputs
  for (genvar c = 0; c < NUM_CH; c++) begin : g_flat
    assign base_addr_flat[c*WORD_W +: WORD_W]  = base_addr_q[c];
    assign base_count_flat[c*WORD_W +: WORD_W] = base_count_q[c];
  end

  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign commit          = commit_q;
  assign commit_ch       = commit_ch_q;
  assign commit_is_count = commit_is_count_q;
  assign byte_ptr        = ptr_q;

endmodule

// File: tb/tb_dma_word_access_buffer.sv
// -----------------------------------------------------------------------------
// tb_dma_word_access_buffer
//
// Self-checking bench for dma_word_access_buffer (NUM_CH=4, 8-bit bus, 16-bit
// words). A small reference model of the byte pointer, staging bytes, read
// snapshot and base words runs alongside the stimulus tasks. Each read or
// committed write pushes its expected result to a queue, and a negedge
// monitor pops and compares entries when the DUT pulses rd_valid or commit.
// -----------------------------------------------------------------------------
module tb_dma_word_access_buffer;

  localparam int NUM_CH = 4;
  localparam int WW     = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        data_bus;
  logic [3:0]        reg_addr;
  logic              wr_en;
  logic              rd_en;
  logic [NUM_CH*WW-1:0] cur_addr_flat;
  logic [NUM_CH*WW-1:0] cur_count_flat;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [NUM_CH*WW-1:0] base_addr_flat;
  logic [NUM_CH*WW-1:0] base_count_flat;
  logic              commit;
  logic [1:0]        commit_ch;
  logic              commit_is_count;
  logic [0:0]        byte_ptr;

  dma_word_access_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .data_bus        (data_bus),
    .reg_addr        (reg_addr),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .cur_addr_flat   (cur_addr_flat),
    .cur_count_flat  (cur_count_flat),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .base_addr_flat  (base_addr_flat),
    .base_count_flat (base_count_flat),
    .commit          (commit),
    .commit_ch       (commit_ch),
    .commit_is_count (commit_is_count),
    .byte_ptr        (byte_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic        is_cnt;
    logic [15:0] word;
  } commit_t;

  commit_t    commit_sb[$];
  logic [7:0] rd_sb[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model state
  logic       m_ptr;
  logic [7:0] m_stage[2];
  logic [15:0] m_snap;
  logic [15:0] m_addr[NUM_CH];
  logic [15:0] m_cnt[NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  commit_t    mon_c;
  logic [7:0] mon_b;
  always @(negedge clk) begin
    if (rd_valid) begin
      if (rd_sb.size() == 0) check("rd_valid_unexpected", 32'd1, 32'd0);
      else begin
        mon_b = rd_sb.pop_front();
        check("rd_data", 32'(rd_data), 32'(mon_b));
      end
    end
    if (commit) begin
      if (commit_sb.size() == 0) check("commit_unexpected", 32'd1, 32'd0);
      else begin
        mon_c = commit_sb.pop_front();
        check("commit_ch", 32'(commit_ch), 32'(mon_c.ch));
        check("commit_is_count", 32'(commit_is_count), 32'(mon_c.is_cnt));
        check("commit_word",
              32'(mon_c.is_cnt ? base_count_flat[mon_c.ch*WW +: WW]
                               : base_addr_flat[mon_c.ch*WW +: WW]),
              32'(mon_c.word));
      end
    end
  end

  task automatic model_clear();
    m_ptr      = 1'b0;
    m_stage[0] = '0;
    m_stage[1] = '0;
    m_snap     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_addr[c] = '0;
      m_cnt[c]  = '0;
    end
  endtask

  task automatic model_write(input logic [3:0] a, input logic [7:0] d);
    logic [15:0] w;
    if (a < 4'd8) begin
      m_stage[m_ptr] = d;
      if (m_ptr) begin
        w = {d, m_stage[0]};
        commit_sb.push_back('{ch: a[2:1], is_cnt: a[0], word: w});
        if (a[0]) m_cnt[a[2:1]] = w;
        else      m_addr[a[2:1]] = w;
        m_ptr = 1'b0;
      end else begin
        m_ptr = 1'b1;
      end
    end else if (a == 4'hC) begin
      m_ptr = 1'b0;
    end else if (a == 4'hD) begin
      m_ptr      = 1'b0;
      m_stage[0] = '0;
      m_stage[1] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_addr[c] = '0;
        m_cnt[c]  = '0;
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    model_write(a, d);
    reg_addr = a;
    data_bus = d;
    wr_en    = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    if (a < 4'd8) begin
      if (!m_ptr) begin
        m_snap = a[0] ? cur_count_flat[a[2:1]*WW +: WW] : cur_addr_flat[a[2:1]*WW +: WW];
        rd_sb.push_back(m_snap[7:0]);
      end else begin
        rd_sb.push_back(m_snap[15:8]);
      end
      m_ptr = ~m_ptr;
    end
    reg_addr = a;
    rd_en    = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic wr_rd(input logic [3:0] a, input logic [7:0] d);
    model_write(a, d);
    reg_addr = a;
    data_bus = d;
    wr_en    = 1'b1;
    rd_en    = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_state();
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("base_addr%0d", c), 32'(base_addr_flat[c*WW +: WW]), 32'(m_addr[c]));
      check($sformatf("base_count%0d", c), 32'(base_count_flat[c*WW +: WW]), 32'(m_cnt[c]));
    end
    check("byte_ptr", 32'(byte_ptr), 32'(m_ptr));
  endtask

  initial begin
    reset          = 1'b1;
    data_bus       = '0;
    reg_addr       = '0;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    cur_addr_flat  = '0;
    cur_count_flat = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_commit_ch", 32'(commit_ch), 32'd0);
    check("rst_commit_is_count", 32'(commit_is_count), 32'd0);
    check_state();

    // 1: two-byte write to address reg of ch1
    wr(4'd2, 8'h34);
    check("t1_no_partial", 32'(base_addr_flat[1*WW +: WW]), 32'h0);
    check("t1_ptr_mid", 32'(byte_ptr), 32'd1);
    wr(4'd2, 8'h12);
    check("t1_word", 32'(base_addr_flat[1*WW +: WW]), 32'h1234);
    check_state();

    // 2: clear flip-flop mid-word, then a fresh word to count ch0
    wr(4'd1, 8'hAA);
    wr(4'hC, 8'h00);
    check("t2_clr_ptr", 32'(byte_ptr), 32'd0);
    wr(4'd1, 8'h55);
    wr(4'd1, 8'h66);
    check("t2_word", 32'(base_count_flat[0 +: WW]), 32'h6655);
    check_state();

    // 3: read count ch3 through the snapshot while the live value changes
    cur_count_flat[3*WW +: WW] = 16'hBEEF;
    rd(4'd7);
    cur_count_flat[3*WW +: WW] = 16'h0000;
    rd(4'd7);
    @(posedge clk);
    #1;
    check("t3_rd_hold", 32'(rd_data), 32'hBE);
    check("t3_ptr", 32'(byte_ptr), 32'd0);

    // Reads of every address register with random live values
    for (int c = 0; c < NUM_CH; c++) begin
      cur_addr_flat[c*WW +: WW] = 16'($urandom());
      rd(4'(2 * c));
      rd(4'(2 * c));
    end

    // 4: reset mid-word discards the partial byte
    wr(4'd0, 8'h11);
    do_reset();
    check_state();
    wr(4'd0, 8'h22);
    wr(4'd0, 8'h33);
    check("t4_word", 32'(base_addr_flat[0 +: WW]), 32'h3322);

    // 5: simultaneous write and read: write performed, read dropped
    wr_rd(4'd4, 8'h77);
    check("t5_ptr", 32'(byte_ptr), 32'd1);
    wr(4'd4, 8'h88);
    check("t5_word", 32'(base_addr_flat[2*WW +: WW]), 32'h8877);

    // Address change mid-word: commit goes to the reg addressed on the last byte
    wr(4'd3, 8'h01);
    wr(4'd5, 8'h02);
    check("mid_addr_word", 32'(base_count_flat[2*WW +: WW]), 32'h0201);

    // 6: load all regs, then master clear
    for (int r = 0; r < 2 * NUM_CH; r++) begin
      logic [15:0] w;
      w = 16'($urandom());
      wr(4'(r), w[7:0]);
      wr(4'(r), w[15:8]);
    end
    check_state();
    wr(4'd6, 8'h5A);
    wr(4'hD, 8'h00);
    check("t6_mclr_addr", 32'(base_addr_flat), 32'h0);
    check("t6_mclr_count", 32'(base_count_flat), 32'h0);
    check_state();
    wr(4'h9, 8'h42);
    rd(4'h9);
    check("t6_bad_addr_ptr", 32'(byte_ptr), 32'd0);
    check_state();

    repeat (2) @(posedge clk);
    #1;
    check("rd_sb_empty", 32'(rd_sb.size()), 32'd0);
    check("commit_sb_empty", 32'(commit_sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
